link_arbiter: RTL

LINK_ARBITER -- requirements
Module: link_arbiter

---
 rtl/link_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/link_arbiter.sv
// rtl/link_arbiter.sv - round-robin two-channel frame arbiter driving a dual-rail four-phase link
// Optional ack timeout: define LINK_ARBITER_TIMEOUT_EN.
module link_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic req1,
  input  logic up1,
  input  logic req2,
  input  logic up2,
  input  logic ack,
  output logic bit0_out,
  output logic bit1_out,
  output logic done1,
  output logic done2,
  output logic busy,
  output logic err
);

  typedef enum logic [1:0] {IDLE, DRIVE, RELEASE, DONE} state_t;

  state_t     state, state_nx;
  logic       ack_m, ack_s;
  logic       gnt, gnt_nx;            // 0 = ch1, 1 = ch2
  logic       cmd, cmd_nx;
  logic       last_gnt, last_gnt_nx;
  logic [1:0] idx, idx_nx;
  logic [1:0] sym_nx;
  logic       done1_nx, done2_nx, err_nx;
  logic       tmo;

`ifdef LINK_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;

  // Fires on the last allowed cycle so the exit edge lands exactly TIMEOUT_CYCLES after entry.
  assign tmo = ((state == DRIVE) || (state == RELEASE)) && (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (state_nx != state)
      cnt <= '0;
    else if ((state == DRIVE) || (state == RELEASE))
      cnt <= cnt + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= ack;
      ack_s <= ack_m;
    end
  end

  always_comb begin
    state_nx    = state;
    gnt_nx      = gnt;
    cmd_nx      = cmd;
    idx_nx      = idx;
    last_gnt_nx = last_gnt;
    err_nx      = 1'b0;
    case (state)
      IDLE: begin
        if (req1 || req2) begin
          if (req1 && req2)
            gnt_nx = ~last_gnt;
          else
            gnt_nx = req2;
          cmd_nx   = gnt_nx ? up2 : up1;
          idx_nx   = 2'd0;
          state_nx = DRIVE;
        end
      end
      DRIVE: begin
        if (tmo) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else if (ack_s) begin
          state_nx = RELEASE;
        end
      end
      RELEASE: begin
        if (tmo) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else if (!ack_s) begin
          if (idx == 2'd3) begin
            state_nx = DONE;
          end else begin
            idx_nx   = idx + 2'd1;
            state_nx = DRIVE;
          end
        end
      end
      DONE: begin
        last_gnt_nx = gnt;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so they line up with the state register.
  always_comb begin
    sym_nx = 2'b00;
    if (state_nx == DRIVE) begin
      case (idx_nx)
        2'd0:    sym_nx = 2'b11;
        2'd1:    sym_nx = gnt_nx ? 2'b10 : 2'b01;
        2'd2:    sym_nx = cmd_nx ? 2'b10 : 2'b01;
        default: sym_nx = 2'b11;
      endcase
    end
    done1_nx = (state_nx == DONE) && !gnt_nx;
    done2_nx = (state_nx == DONE) && gnt_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      cmd      <= 1'b0;
      idx      <= 2'd0;
      last_gnt <= 1'b1;
      bit0_out <= 1'b0;
      bit1_out <= 1'b0;
      done1    <= 1'b0;
      done2    <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      cmd      <= cmd_nx;
      idx      <= idx_nx;
      last_gnt <= last_gnt_nx;
      bit0_out <= sym_nx[0];
      bit1_out <= sym_nx[1];
      done1    <= done1_nx;
      done2    <= done2_nx;
      busy     <= (state_nx != IDLE);
      err      <= err_nx;
    end
  end

endmodule
